rca_hot_loop_selector: RTL

Hardware initiator for the RCA profile cache's CPU-side read port. On a profiler threshold exception it locks the profile cache, walks every entry over the profiler's request/writeback handshake, picks the hottest valid short-backward-branch entry, unlocks the cache, and presents the winner's branch PC and taken count to the sequence-extraction logic. It sits between `rca_profiler` and the downstream RCA configuration pipeline, and replaces the software selection routine.

---
 rtl/rca_hot_loop_selector.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rca_hot_loop_selector.sv
// Hardware selector for the RCA profile cache: locks the cache, walks every entry
// over the profiler's request/writeback handshake, and presents the hottest valid entry.
module rca_hot_loop_selector #(
    parameter int NUM_ENTRIES = 8,
    parameter int COUNT_W     = 8,
    parameter int XLEN        = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           profiler_exception,
    output logic                           req_valid,
    input  logic                           req_ready,
    output logic                           req_toggle_lock,
    output logic [$clog2(NUM_ENTRIES)-1:0] req_entry_index,
    output logic [1:0]                     req_field_id,
    input  logic                           rsp_done,
    input  logic [XLEN-1:0]                rsp_data,
    output logic                           rsp_ack,
    output logic                           sel_valid,
    input  logic                           sel_ready,
    output logic                           sel_found,
    output logic [XLEN-1:0]                sel_branch_pc,
    output logic [COUNT_W-1:0]             sel_taken_count,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    localparam logic [1:0] FIELD_ADDR  = 2'd0;
    localparam logic [1:0] FIELD_VALID = 2'd1;
    localparam logic [1:0] FIELD_COUNT = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOCK,
        RD_VALID,
        RD_COUNT,
        RD_ADDR,
        UNLOCK,
        PRESENT
    } state_t;

    state_t             state_reg, state_next;
    logic               wait_reg, wait_next;
    logic               pending_reg, pending_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic [COUNT_W-1:0] best_count_reg, best_count_next;
    logic [COUNT_W-1:0] cand_reg, cand_next;
    logic [XLEN-1:0]    best_pc_reg, best_pc_next;
    logic               found_reg, found_next;

    logic               in_txn;
    logic               advance;
    logic [COUNT_W-1:0] rsp_count;

    // Every state except IDLE and PRESENT runs exactly one profiler transaction.
    assign in_txn    = (state_reg != IDLE) && (state_reg != PRESENT);
    assign rsp_count = rsp_data[COUNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wait_reg       <= 1'b0;
            pending_reg    <= 1'b0;
            index_reg      <= '0;
            best_count_reg <= '0;
            cand_reg       <= '0;
            best_pc_reg    <= '0;
            found_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_reg       <= wait_next;
            pending_reg    <= pending_next;
            index_reg      <= index_next;
            best_count_reg <= best_count_next;
            cand_reg       <= cand_next;
            best_pc_reg    <= best_pc_next;
            found_reg      <= found_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_next       = wait_reg;
        pending_next    = pending_reg;
        index_next      = index_reg;
        best_count_next = best_count_reg;
        cand_next       = cand_reg;
        best_pc_next    = best_pc_reg;
        found_next      = found_reg;
        advance         = 1'b0;

        // Exceptions that arrive while a scan is running merge into one rescan.
        if (profiler_exception && (state_reg != IDLE)) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (profiler_exception || pending_reg) begin
                    state_next      = LOCK;
                    wait_next       = 1'b0;
                    pending_next    = 1'b0;
                    index_next      = '0;
                    best_count_next = '0;
                    best_pc_next    = '0;
                    found_next      = 1'b0;
                end
            end
            PRESENT: begin
                if (sel_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (!wait_reg) begin
                    if (req_ready) begin
                        wait_next = 1'b1;
                    end
                end else if (rsp_done) begin
                    wait_next = 1'b0;
                    case (state_reg)
                        LOCK:     state_next = RD_VALID;
                        RD_VALID: begin
                            if (rsp_data[0]) begin
                                state_next = RD_COUNT;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        RD_COUNT: begin
                            // Strict compare keeps the lowest index on ties.
                            if ((rsp_count > best_count_reg) || !found_reg) begin
                                cand_next  = rsp_count;
                                state_next = RD_ADDR;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        RD_ADDR: begin
                            best_pc_next    = rsp_data;
                            best_count_next = cand_reg;
                            found_next      = 1'b1;
                            advance         = 1'b1;
                        end
                        UNLOCK:   state_next = PRESENT;
                        default:  state_next = IDLE;
                    endcase
                end
            end
        endcase

        if (advance) begin
            if (index_reg == LAST_IDX) begin
                state_next = UNLOCK;
            end else begin
                index_next = index_reg + IDX_W'(1);
                state_next = RD_VALID;
            end
        end
    end

    always_comb begin
        req_field_id = FIELD_ADDR;
        case (state_reg)
            RD_VALID: req_field_id = FIELD_VALID;
            RD_COUNT: req_field_id = FIELD_COUNT;
            default:  req_field_id = FIELD_ADDR;
        endcase
    end

    assign req_valid       = in_txn && !wait_reg;
    assign req_toggle_lock = ((state_reg == LOCK) || (state_reg == UNLOCK)) && !wait_reg;
    assign req_entry_index = index_reg;
    assign rsp_ack         = in_txn && wait_reg && rsp_done;
    assign sel_valid       = (state_reg == PRESENT);
    assign sel_found       = found_reg;
    assign sel_branch_pc   = best_pc_reg;
    assign sel_taken_count = best_count_reg;
    assign busy            = (state_reg != IDLE);

endmodule
